// File: rtl/mult_div_unit_if.sv
// Handshake and data bundle for the multiply/divide unit.
// master drives start/op/a/b/mthi/mtlo/wdata; slave returns busy/done/div_by_zero/hi/lo.
interface mult_div_unit_if #(
    parameter int SIZE = 32
);
    logic            start;
    logic [1:0]      op;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            mthi;
    logic            mtlo;
    logic [SIZE-1:0] wdata;
    logic            busy;
    logic            done;
    logic            div_by_zero;
    logic [SIZE-1:0] hi;
    logic [SIZE-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit, one bit per cycle.
// Ports: clk, rst_n (async low), bus (slave): start/op/a/b, mthi/mtlo/wdata, busy/done/div_by_zero/hi/lo.
module mult_div_unit #(
    parameter int SIZE = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_div_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state;
    state_t state_nx;

    logic [5:0]      cnt;
    logic            is_div;
    logic            neg_q;
    logic            neg_r;
    logic            dbz;
    logic [SIZE-1:0] acc;
    logic [SIZE-1:0] mq;
    logic [SIZE-1:0] opb;
    logic [SIZE-1:0] hi_q;
    logic [SIZE-1:0] lo_q;
    logic            done_q;
    logic            dbz_q;

    logic            sgn;
    logic            sa;
    logic            sb;
    logic [SIZE-1:0] mag_a;
    logic [SIZE-1:0] mag_b;
    logic [SIZE:0]   add_s;
    logic [SIZE:0]   sh;
    logic [SIZE:0]   sub_s;
    logic [2*SIZE-1:0] prod_fix;
    logic [SIZE-1:0] q_fix;
    logic [SIZE-1:0] r_fix;

    // Signed ops work on magnitudes; signs are reapplied in FIX.
    assign sgn   = ~bus.op[0];
    assign sa    = sgn & bus.a[SIZE-1];
    assign sb    = sgn & bus.b[SIZE-1];
    assign mag_a = sa ? -bus.a : bus.a;
    assign mag_b = sb ? -bus.b : bus.b;

    // Multiply: {acc,mq} shifts right, adding the multiplicand into acc.
    assign add_s = {1'b0, acc} + {1'b0, (mq[0] ? opb : '0)};

    // Restoring divide: remainder in acc, dividend shifts out of mq.
    assign sh    = {acc, mq[SIZE-1]};
    assign sub_s = sh - {1'b0, opb};

    assign prod_fix = neg_q ? -{acc, mq} : {acc, mq};
    assign q_fix    = neg_q ? -mq : mq;
    assign r_fix    = neg_r ? -acc : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.start) state_nx = CALC;
            CALC: if (cnt == 6'd31) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz    <= 1'b0;
            acc    <= '0;
            mq     <= '0;
            opb    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt    <= '0;
                        is_div <= bus.op[1];
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        dbz    <= bus.op[1] & (bus.b == '0);
                        acc    <= '0;
                        mq     <= mag_a;
                        opb    <= mag_b;
                    end else begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    if (is_div) begin
                        if (!sub_s[SIZE]) begin
                            acc <= sub_s[SIZE-1:0];
                            mq  <= {mq[SIZE-2:0], 1'b1};
                        end else begin
                            acc <= sh[SIZE-1:0];
                            mq  <= {mq[SIZE-2:0], 1'b0};
                        end
                    end else begin
                        acc <= add_s[SIZE:1];
                        mq  <= {add_s[0], mq[SIZE-1:1]};
                    end
                end
                FIX: begin
                    done_q <= 1'b1;
                    dbz_q  <= dbz;
                    if (is_div) begin
                        // With b==0 the remainder path already holds |a|.
                        lo_q <= dbz ? '1 : q_fix;
                        hi_q <= r_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus corner sequences.
// Expected results are queued at start and checked when done pulses.
module tb_mult_div_unit;
    logic clk;
    logic rst_n;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    vec_t vt [13];
    exp_t sbq [$];
    int n_cmp;
    int n_fail;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_start(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] eh,
                               input logic [31:0] el, input logic ed);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        e.hi  = eh;
        e.lo  = el;
        e.dbz = ed;
        sbq.push_back(e);
    endtask

    // Waits for E0, then counts edges until done; inj>0 fires a
    // start+mthi pair at that cycle which must be ignored.
    task automatic wait_done(input int inj);
        exp_t e;
        int n;
        bit got;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (inj != 0 && n == inj) begin
                bus.start = 1'b1;
                bus.op    = MULTU;
                bus.a     = 32'd1;
                bus.b     = 32'd1;
                bus.mthi  = 1'b1;
                bus.wdata = 32'h1234;
            end else if (inj != 0 && n == inj + 1) begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
                check("mthi_ignored_busy", {32'd0, bus.hi}, {32'd0, m_hi});
            end
            if (n == 5) begin
                check("busy_calc", {63'd0, bus.busy}, 64'd1);
                check("hold_hi", {32'd0, bus.hi}, {32'd0, m_hi});
                check("hold_lo", {32'd0, bus.lo}, {32'd0, m_lo});
            end
            if (bus.done) got = 1'b1;
        end
        check("done_seen", {63'd0, got}, 64'd1);
        if (got) begin
            check("sb_nonempty", {63'd0, sbq.size() != 0}, 64'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("latency", 64'(n), 64'd33);
                check("hi", {32'd0, bus.hi}, {32'd0, e.hi});
                check("lo", {32'd0, bus.lo}, {32'd0, e.lo});
                check("dbz", {63'd0, bus.div_by_zero}, {63'd0, e.dbz});
                check("busy_done", {63'd0, bus.busy}, 64'd0);
                m_hi = e.hi;
                m_lo = e.lo;
            end
        end
        @(posedge clk);
        #1;
        check("done_pulse", {63'd0, bus.done}, 64'd0);
        check("idle_after", {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        vt[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vt[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vt[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vt[3]  = '{DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
        vt[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vt[5]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vt[6]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vt[7]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vt[8]  = '{DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
        vt[9]  = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vt[10] = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vt[11] = '{MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};
        vt[12] = '{DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;
        m_hi      = '0;
        m_lo      = '0;
        #3;
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive_start(vt[i].op, vt[i].a, vt[i].b,
                        vt[i].hi, vt[i].lo, vt[i].dbz);
            wait_done(0);
        end

        // start and mthi mid-operation are both dropped
        drive_start(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        wait_done(10);

        @(negedge clk);
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hABCD;
        @(posedge clk);
        #1;
        bus.mtlo = 1'b0;
        check("mtlo_lo", {32'd0, bus.lo}, 64'h0000ABCD);
        check("mtlo_hi", {32'd0, bus.hi}, 64'd2);
        m_lo = 32'hABCD;

        @(negedge clk);
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h77;
        @(posedge clk);
        #1;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mt_both_hi", {32'd0, bus.hi}, 64'h77);
        check("mt_both_lo", {32'd0, bus.lo}, 64'h77);
        m_hi = 32'h77;
        m_lo = 32'h77;

        // start wins over mthi in the same cycle
        drive_start(MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        bus.mthi  = 1'b1;
        bus.wdata = 32'h5555;
        wait_done(0);

        // reset mid-operation aborts with no done
        drive_start(MULT, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0);
        void'(sbq.pop_back());
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_hi", {32'd0, bus.hi}, 64'd0);
        check("arst_lo", {32'd0, bus.lo}, 64'd0);
        check("arst_busy", {63'd0, bus.busy}, 64'd0);
        check("arst_done", {63'd0, bus.done}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b1;
        bus.op    = MULTU;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        begin
            exp_t e;
            e.hi  = 32'd0;
            e.lo  = 32'd12;
            e.dbz = 1'b0;
            sbq.push_back(e);
        end
        wait_done(0);

        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
